adder_result_accumulator: RTL and testbench

Downstream consumer of the 5-bit ripple adder stage. Each accepted beat takes the adder's 5-bit sum plus its carry-out as one 6-bit unsigned operand. The block accumulates a fixed-length frame of NUM_OPS such operands into an ACC_W-bit total. It then presents the total, an operand count and a sticky overflow flag on a valid/ready output port until it is consumed.

---
 rtl/adder_acc_pkg.sv | 13 +
 rtl/acc_adder.sv | 17 +
 rtl/adder_result_accumulator.sv | 119 +++++++++++
 tb/tb_adder_result_accumulator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_acc_pkg.sv
// Shared definitions for the adder result accumulator: state encoding and fixed widths.
package adder_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int OPERAND_W = 6;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/acc_adder.sv
// Unsigned ACC_W-bit adder returning the wrapped sum and the carry out of the top bit.
module acc_adder #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);

    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o    = full_sum[ACC_W-1:0];
    assign carry_o  = full_sum[ACC_W];

endmodule

// File: rtl/adder_result_accumulator.sv
// Accumulates NUM_OPS adder results ({carry, z}) into a frame total with sticky overflow,
// then presents the total on a valid/ready port until consumed.
module adder_result_accumulator
    import adder_acc_pkg::*;
#(
    parameter int NUM_OPS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_z,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [3:0]       out_count,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   operand;
    logic [ACC_W-1:0]   step_sum;
    logic               step_carry;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;

    assign operand  = ACC_W'({in_carry, in_z});
    assign in_ready = (state_q != DONE) && !clear;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    acc_adder #(
        .ACC_W (ACC_W)
    ) u_acc_adder (
        .a_i     (acc_q),
        .b_i     (operand),
        .sum_o   (step_sum),
        .carry_o (step_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = operand;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = step_sum;
                    ovf_d = ovf_q | step_carry;
                    cnt_d = cnt_inc;
                    if (cnt_inc == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase

        // Abort wins over every transition above, including a pending DONE result.
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed, table-driven bench for adder_result_accumulator (NUM_OPS=4 and NUM_OPS=5 instances).
module tb_adder_result_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_valid5 = 1'b0;
    logic [4:0] in_z = '0;
    logic       in_carry = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_ovf;
    logic [7:0] out_sum;
    logic [3:0] out_count;

    logic       in_ready5, out_valid5, out_ovf5;
    logic [7:0] out_sum5;
    logic [3:0] out_count5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_result_accumulator #(.NUM_OPS(4), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    adder_result_accumulator #(.NUM_OPS(5), .ACC_W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid5), .in_ready(in_ready5),
        .in_z(in_z), .in_carry(in_carry),
        .out_valid(out_valid5), .out_ready(out_ready),
        .out_sum(out_sum5), .out_count(out_count5), .out_ovf(out_ovf5)
    );

    typedef struct {
        logic [5:0] op;
        int         exp_sum;
        int         exp_cnt;
        int         exp_valid;
        int         exp_ovf;
    } vec_t;

    vec_t basic [4];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat for a single cycle on the selected instance.
    task automatic beat(input logic [5:0] op, input bit to5);
        {in_carry, in_z} = op;
        if (to5) in_valid5 = 1'b1;
        else     in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        in_valid5 = 1'b0;
    endtask

    task automatic run_table(input int gap);
        for (int i = 0; i < 4; i++) begin
            repeat (gap) begin
                step();
                check("gap_hold_count", out_count, (i == 0) ? 0 : basic[i-1].exp_cnt);
            end
            beat(basic[i].op, 1'b0);
            check("frame_sum",   out_sum,   basic[i].exp_sum);
            check("frame_count", out_count, basic[i].exp_cnt);
            check("frame_valid", out_valid, basic[i].exp_valid);
            check("frame_ovf",   out_ovf,   basic[i].exp_ovf);
        end
    endtask

    initial begin
        // {0,5}=5, {1,31}=63, {1,0}=32, {0,10}=10 -> running totals 5, 68, 100, 110
        basic[0] = '{6'd5,  5,   1, 0, 0};
        basic[1] = '{6'd63, 68,  2, 0, 0};
        basic[2] = '{6'd32, 100, 3, 0, 0};
        basic[3] = '{6'd10, 110, 4, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf",   out_ovf,   0);
        check("rst_in_ready",  in_ready,  1);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready",  in_ready,  1);
        check("post_rst_in_ready5", in_ready5, 1);

        // Basic back-to-back frame
        run_table(0);
        check("done_in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("handshake_valid", out_valid, 0);
        check("handshake_count", out_count, 0);
        check("handshake_sum",   out_sum,   0);
        check("handshake_ready", in_ready,  1);

        // Gapped frame followed by backpressure with stray beats
        run_table(2);
        {in_carry, in_z} = 6'd63;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_valid",    out_valid, 1);
            check("bp_sum",      out_sum,   110);
            check("bp_count",    out_count, 4);
            check("bp_ovf",      out_ovf,   0);
            check("bp_in_ready", in_ready,  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready,  1);

        // Overflow: five beats of 63 on the NUM_OPS=5 instance
        for (int i = 0; i < 4; i++) beat(6'd63, 1'b1);
        check("ovf_pre_sum",   out_sum5,   252);
        check("ovf_pre_flag",  out_ovf5,   0);
        check("ovf_pre_valid", out_valid5, 0);
        beat(6'd63, 1'b1);
        check("ovf_sum",   out_sum5,   59);
        check("ovf_flag",  out_ovf5,   1);
        check("ovf_count", out_count5, 5);
        check("ovf_valid", out_valid5, 1);
        check("ovf_idle_other", out_valid, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ovf_release_valid", out_valid5, 0);
        check("ovf_release_flag",  out_ovf5,   0);

        // Clear mid-frame with a beat presented in the same cycle
        beat(6'd1, 1'b0);
        beat(6'd1, 1'b0);
        check("clr_pre_count", out_count, 2);
        clear = 1'b1;
        in_valid = 1'b1;
        {in_carry, in_z} = 6'd5;
        #1;
        check("clr_in_ready", in_ready, 0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_count", out_count, 0);
        check("clr_sum",   out_sum,   0);
        check("clr_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) beat(6'd1, 1'b0);
        check("clr_next_sum",   out_sum,   4);
        check("clr_next_ovf",   out_ovf,   0);
        check("clr_next_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Clear while a result is pending in DONE
        for (int i = 0; i < 4; i++) beat(6'd2, 1'b0);
        check("clr_done_valid_pre", out_valid, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_done_valid", out_valid, 0);
        check("clr_done_sum",   out_sum,   0);

        // Asynchronous reset while holding a result in DONE
        for (int i = 0; i < 4; i++) beat(6'd63, 1'b0);
        check("arst_pre_valid", out_valid, 1);
        check("arst_pre_sum",   out_sum,   252);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",    out_valid, 0);
        check("arst_sum",      out_sum,   0);
        check("arst_count",    out_count, 0);
        check("arst_ovf",      out_ovf,   0);
        check("arst_in_ready", in_ready,  1);
        step();
        rst_n = 1'b1;
        step();
        check("arst_release_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
